// File: rtl/add_sched_if.sv
// add_sched_if: requester bundle plus shared-adder link for add_sched.
// master = requesters/adder side, slave = scheduler side.
interface add_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      res;
  logic                  res_cout;
  logic                  busy;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;
`ifdef ADD_SCHED_STATS_EN
  logic [15:0]           stat_ops;
  logic [15:0]           stat_wait;
`endif

  modport master (
    output req, req_a, req_b, req_cin,
    output add_sum, add_cout,
    input  gnt, done, res, res_cout, busy,
`ifdef ADD_SCHED_STATS_EN
    input  stat_ops, stat_wait,
`endif
    input  add_a, add_b, add_cin
  );

  modport slave (
    input  req, req_a, req_b, req_cin,
    input  add_sum, add_cout,
    output gnt, done, res, res_cout, busy,
`ifdef ADD_SCHED_STATS_EN
    output stat_ops, stat_wait,
`endif
    output add_a, add_b, add_cin
  );
endinterface

// File: rtl/add_sched.sv
// add_sched: round-robin sharing of one slow ripple adder among NREQ
// requesters; ports: clk, rst (sync, high), bus (add_sched_if.slave).
// Optional ADD_SCHED_STATS_EN adds stat_ops / stat_wait counters.
module add_sched #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 4
) (
  input logic        clk,
  input logic        rst,
  add_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [IW-1:0]   LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    w, w_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [NREQ-1:0]  gnt_r, gnt_n;
  logic [NREQ-1:0]  done_r, done_n;
  logic [WIDTH-1:0] res_r, res_n;
  logic             cout_r, cout_n;
  logic             busy_r, busy_n;
  logic [WIDTH-1:0] a_r, a_n;
  logic [WIDTH-1:0] b_r, b_n;
  logic             cin_r, cin_n;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [IW-1:0]    win;
  int unsigned      j;

  // A requester finishing this cycle may still hold req; keep it
  // out so it cannot be re-granted back-to-back.
  assign elig = bus.req & ~done_r;

  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    w_n     = w;
    ptr_n   = ptr;
    gnt_n   = gnt_r;
    done_n  = '0;
    res_n   = res_r;
    cout_n  = cout_r;
    busy_n  = busy_r;
    a_n     = a_r;
    b_n     = b_r;
    cin_n   = cin_r;
    unique case (state)
      IDLE: begin
        if (found) begin
          a_n     = bus.req_a[win*WIDTH +: WIDTH];
          b_n     = bus.req_b[win*WIDTH +: WIDTH];
          cin_n   = bus.req_cin[win];
          gnt_n   = ONE << win;
          busy_n  = 1'b1;
          cnt_n   = CW'(SETTLE_CYC - 1);
          w_n     = win;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_n = CAPT;
        else           cnt_n   = cnt - 1'b1;
      end
      CAPT: begin
        res_n   = bus.add_sum;
        cout_n  = bus.add_cout;
        done_n  = ONE << w;
        gnt_n   = '0;
        busy_n  = 1'b0;
        ptr_n   = (w == LAST) ? '0 : w + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      w      <= '0;
      ptr    <= '0;
      gnt_r  <= '0;
      done_r <= '0;
      res_r  <= '0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      cin_r  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      w      <= w_n;
      ptr    <= ptr_n;
      gnt_r  <= gnt_n;
      done_r <= done_n;
      res_r  <= res_n;
      cout_r <= cout_n;
      busy_r <= busy_n;
      a_r    <= a_n;
      b_r    <= b_n;
      cin_r  <= cin_n;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.res      = res_r;
  assign bus.res_cout = cout_r;
  assign bus.busy     = busy_r;
  assign bus.add_a    = a_r;
  assign bus.add_b    = b_r;
  assign bus.add_cin  = cin_r;

`ifdef ADD_SCHED_STATS_EN
  logic [15:0] ops_r;
  logic [15:0] wait_r;
  logic        waiting;

  assign waiting = |(bus.req & ~gnt_r & ~done_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_r  <= '0;
      wait_r <= '0;
    end else begin
      if (state == CAPT && ops_r != 16'hFFFF)
        ops_r <= ops_r + 16'd1;
      if (waiting && wait_r != 16'hFFFF)
        wait_r <= wait_r + 16'd1;
    end
  end

  assign bus.stat_ops  = ops_r;
  assign bus.stat_wait = wait_r;
`endif
endmodule
